// File: rtl/pg_ab_commit_arb.sv
// pg_ab_commit_arb: merges the A and B host-bound TLP streams into one TX stream and
// returns a local write-commit completion on RX B for every write leaving on the merged stream.
module pg_ab_commit_arb #(
  parameter int unsigned TDATA_WIDTH  = 512,
  parameter int unsigned TUSER_WIDTH  = 10,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tx_a_tvalid_i,
  output logic                     tx_a_tready_o,
  input  logic [TDATA_WIDTH-1:0]   tx_a_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] tx_a_tkeep_i,
  input  logic                     tx_a_tlast_i,
  input  logic [TUSER_WIDTH-1:0]   tx_a_tuser_i,
  input  logic                     tx_b_tvalid_i,
  output logic                     tx_b_tready_o,
  input  logic [TDATA_WIDTH-1:0]   tx_b_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] tx_b_tkeep_i,
  input  logic                     tx_b_tlast_i,
  input  logic [TUSER_WIDTH-1:0]   tx_b_tuser_i,
  output logic                     out_tvalid_o,
  input  logic                     out_tready_i,
  output logic [TDATA_WIDTH-1:0]   out_tdata_o,
  output logic [TDATA_WIDTH/8-1:0] out_tkeep_o,
  output logic                     out_tlast_o,
  output logic [TUSER_WIDTH-1:0]   out_tuser_o,
  output logic                     rx_b_tvalid_o,
  input  logic                     rx_b_tready_i,
  output logic [TDATA_WIDTH-1:0]   rx_b_tdata_o,
  output logic [TDATA_WIDTH/8-1:0] rx_b_tkeep_o,
  output logic                     rx_b_tlast_o,
  output logic [TUSER_WIDTH-1:0]   rx_b_tuser_o
);

  localparam int unsigned KeepW = TDATA_WIDTH / 8;
  localparam int unsigned PtrW  = (COMMIT_DEPTH > 1) ? $clog2(COMMIT_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0] CreditInit = CntW'(COMMIT_DEPTH);

  typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_e;

  function automatic logic is_wr(input logic [7:0] fmt_type);
    return (fmt_type == 8'h40) || (fmt_type == 8'h60);
  endfunction

  state_e          state_q, state_d;
  logic            last_b_q, last_b_d;  // 1: B was served last, so A wins the next tie
  logic [CntW-1:0] credits_q, credits_d;

  logic a_wr, b_wr, a_elig, b_elig, grant_a, grant_b, out_ready;
  logic acc_a, acc_b, acc, sop_wr, sel_wr;

  logic [TDATA_WIDTH-1:0] sel_tdata;
  logic [KeepW-1:0]       sel_tkeep;
  logic                   sel_tlast;
  logic [TUSER_WIDTH-1:0] sel_tuser;

  logic                   out_tvalid_q, out_tlast_q, out_wr_q;
  logic [TDATA_WIDTH-1:0] out_tdata_q;
  logic [KeepW-1:0]       out_tkeep_q;
  logic [TUSER_WIDTH-1:0] out_tuser_q;

  logic [255:0]           hdr_q, commit_hdr;
  logic [TUSER_WIDTH-1:0] hdr_user_q;

  logic [255:0]           hdr_mem [COMMIT_DEPTH];
  logic [TUSER_WIDTH-1:0] usr_mem [COMMIT_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   push, pop, rx_valid;

  // Arbitration: grant, per-input tready and packet-lock state transitions.
  always_comb begin
    a_wr      = is_wr(tx_a_tdata_i[31:24]);
    b_wr      = is_wr(tx_b_tdata_i[31:24]);
    // Writes on either side need a credit so the commit FIFO can never overflow.
    a_elig    = tx_a_tvalid_i && (!a_wr || (credits_q != '0));
    b_elig    = tx_b_tvalid_i && (!b_wr || (credits_q != '0));
    out_ready = !out_tvalid_q || out_tready_i;
    state_d   = state_q;
    last_b_d  = last_b_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_elig && b_elig) begin
          grant_a = last_b_q;
          grant_b = !last_b_q;
        end else begin
          grant_a = a_elig;
          grant_b = b_elig;
        end
      end
      StLockA: grant_a = 1'b1;
      StLockB: grant_b = 1'b1;
      default: ;
    endcase
    tx_a_tready_o = grant_a && out_ready;
    tx_b_tready_o = grant_b && out_ready;
    acc_a  = tx_a_tready_o && tx_a_tvalid_i;
    acc_b  = tx_b_tready_o && tx_b_tvalid_i;
    acc    = acc_a || acc_b;
    sop_wr = (state_q == StIdle) && ((acc_a && a_wr) || (acc_b && b_wr));
    if (acc_a) begin
      state_d = tx_a_tlast_i ? StIdle : StLockA;
      if (tx_a_tlast_i) last_b_d = 1'b0;
    end else if (acc_b) begin
      state_d = tx_b_tlast_i ? StIdle : StLockB;
      if (tx_b_tlast_i) last_b_d = 1'b1;
    end
  end

  // Beat mux for the accepted input.
  always_comb begin
    sel_tdata = acc_b ? tx_b_tdata_i : tx_a_tdata_i;
    sel_tkeep = acc_b ? tx_b_tkeep_i : tx_a_tkeep_i;
    sel_tlast = acc_b ? tx_b_tlast_i : tx_a_tlast_i;
    sel_tuser = acc_b ? tx_b_tuser_i : tx_a_tuser_i;
    sel_wr    = acc_b ? b_wr : a_wr;
  end

  // Commit push/pop, credit and FIFO occupancy next-state.
  always_comb begin
    push       = out_tvalid_q && out_tready_i && out_tlast_q && out_wr_q;
    rx_valid   = (cnt_q != '0);
    pop        = rx_valid && rx_b_tready_i;
    credits_d  = credits_q + CntW'(pop) - CntW'(sop_wr);
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    commit_hdr = hdr_q;
    commit_hdr[31:24] = 8'h0A;
    commit_hdr[9:0]   = 10'd0;
  end

  // Arbiter state, credits and FIFO pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      credits_q <= CreditInit;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Output register stage plus the saved header of the write in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= '0;
      out_wr_q     <= 1'b0;
      hdr_q        <= '0;
      hdr_user_q   <= '0;
    end else begin
      if (acc) begin
        out_tvalid_q <= 1'b1;
        out_tdata_q  <= sel_tdata;
        out_tkeep_q  <= sel_tkeep;
        out_tlast_q  <= sel_tlast;
        out_tuser_q  <= sel_tuser;
        if (state_q == StIdle) out_wr_q <= sel_wr;
      end else if (out_tready_i) begin
        out_tvalid_q <= 1'b0;
      end
      if (sop_wr) begin
        hdr_q      <= sel_tdata[255:0];
        hdr_user_q <= sel_tuser;
      end
    end
  end

  // Commit FIFO storage; outputs are gated by occupancy so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      hdr_mem[wr_ptr_q] <= commit_hdr;
      usr_mem[wr_ptr_q] <= hdr_user_q;
    end
  end

  assign out_tvalid_o  = out_tvalid_q;
  assign out_tdata_o   = out_tdata_q;
  assign out_tkeep_o   = out_tkeep_q;
  assign out_tlast_o   = out_tlast_q;
  assign out_tuser_o   = out_tuser_q;
  assign rx_b_tvalid_o = rx_valid;
  assign rx_b_tdata_o  = rx_valid ? TDATA_WIDTH'(hdr_mem[rd_ptr_q]) : '0;
  assign rx_b_tkeep_o  = rx_valid ? KeepW'(32'hFFFF_FFFF) : '0;
  assign rx_b_tlast_o  = rx_valid;
  assign rx_b_tuser_o  = rx_valid ? usr_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_pg_ab_commit_arb.sv
// tb_pg_ab_commit_arb: table vectors plus hand sequences, scoreboard queues checked on handshakes.
module tb_pg_ab_commit_arb;
  localparam int TDW = 512;
  localparam int TUW = 10;
  localparam int KW  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           tx_a_tvalid, tx_a_tready, tx_a_tlast;
  logic [TDW-1:0] tx_a_tdata;
  logic [KW-1:0]  tx_a_tkeep;
  logic [TUW-1:0] tx_a_tuser;
  logic           tx_b_tvalid, tx_b_tready, tx_b_tlast;
  logic [TDW-1:0] tx_b_tdata;
  logic [KW-1:0]  tx_b_tkeep;
  logic [TUW-1:0] tx_b_tuser;
  logic           out_tvalid, out_tready, out_tlast;
  logic [TDW-1:0] out_tdata;
  logic [KW-1:0]  out_tkeep;
  logic [TUW-1:0] out_tuser;
  logic           rx_b_tvalid, rx_b_tready, rx_b_tlast;
  logic [TDW-1:0] rx_b_tdata;
  logic [KW-1:0]  rx_b_tkeep;
  logic [TUW-1:0] rx_b_tuser;

  pg_ab_commit_arb #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .COMMIT_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_a_tvalid_i(tx_a_tvalid), .tx_a_tready_o(tx_a_tready), .tx_a_tdata_i(tx_a_tdata),
    .tx_a_tkeep_i(tx_a_tkeep), .tx_a_tlast_i(tx_a_tlast), .tx_a_tuser_i(tx_a_tuser),
    .tx_b_tvalid_i(tx_b_tvalid), .tx_b_tready_o(tx_b_tready), .tx_b_tdata_i(tx_b_tdata),
    .tx_b_tkeep_i(tx_b_tkeep), .tx_b_tlast_i(tx_b_tlast), .tx_b_tuser_i(tx_b_tuser),
    .out_tvalid_o(out_tvalid), .out_tready_i(out_tready), .out_tdata_o(out_tdata),
    .out_tkeep_o(out_tkeep), .out_tlast_o(out_tlast), .out_tuser_o(out_tuser),
    .rx_b_tvalid_o(rx_b_tvalid), .rx_b_tready_i(rx_b_tready), .rx_b_tdata_o(rx_b_tdata),
    .rx_b_tkeep_o(rx_b_tkeep), .rx_b_tlast_o(rx_b_tlast), .rx_b_tuser_o(rx_b_tuser)
  );

  typedef struct packed {
    logic [TDW-1:0] d;
    logic [KW-1:0]  k;
    logic           l;
    logic [TUW-1:0] u;
  } beat_t;

  typedef struct {
    bit       src;
    int       n;
    bit [7:0] fmt;
    bit [7:0] tag;
    int       exp_beats;
    int       exp_commit;
  } vec_t;

  beat_t exp_a[$], exp_b[$], exp_c[$];
  bit    ord_q[$];
  int    pass_cnt = 0, total_cnt = 0;
  int    out_seen = 0, rx_seen = 0, a_acc = 0, b_acc = 0, stall_cnt = 0;
  int    budget = 200;
  beat_t mon_got, mon_held, mon_exp;
  bit    stall_prev = 1'b0;
  bit    mon_src, mon_ord;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_msg(input string name, input string what);
    total_cnt++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic beat_t mk_beat(input bit src, input int idx, input int n,
                                    input bit [7:0] fmt, input bit [7:0] tag);
    beat_t b;
    logic [7:0] i8;
    i8 = idx[7:0];
    b = '0;
    // Payload beats deliberately mimic a write header; only the SOP may be decoded.
    b.d[31:24]   = (idx == 0) ? fmt : 8'h40;
    b.d[9:0]     = (idx == 0) ? 10'd16 : 10'd3;
    b.d[47:40]   = tag;
    b.d[127:96]  = {tag, 8'hA5, i8, 8'h5A};
    b.d[263:256] = i8;
    b.d[264]     = src;
    b.d[511:504] = tag + i8;
    b.l          = (idx == n - 1);
    b.k          = b.l ? 64'h0000_FFFF_FFFF_FFFF : '1;
    b.u          = {src, tag[6:0], i8[1:0]};
    return b;
  endfunction

  function automatic beat_t mk_commit(input beat_t sop);
    beat_t c;
    c = '0;
    c.d[255:0] = sop.d[255:0];
    c.d[31:24] = 8'h0A;
    c.d[9:0]   = 10'd0;
    c.k        = 64'h0000_0000_FFFF_FFFF;
    c.l        = 1'b1;
    c.u        = sop.u;
    return c;
  endfunction

  task automatic push_pkt(input bit src, input int n, input bit [7:0] fmt, input bit [7:0] tag,
                          input bit commit);
    for (int i = 0; i < n; i++) begin
      if (src) exp_b.push_back(mk_beat(src, i, n, fmt, tag));
      else     exp_a.push_back(mk_beat(src, i, n, fmt, tag));
    end
    if (commit) exp_c.push_back(mk_commit(mk_beat(src, 0, n, fmt, tag)));
  endtask

  task automatic drive(input bit src, input beat_t b, input bit v);
    if (!src) begin
      tx_a_tvalid = v; tx_a_tdata = b.d; tx_a_tkeep = b.k; tx_a_tlast = b.l; tx_a_tuser = b.u;
    end else begin
      tx_b_tvalid = v; tx_b_tdata = b.d; tx_b_tkeep = b.k; tx_b_tlast = b.l; tx_b_tuser = b.u;
    end
  endtask

  task automatic wait_accept(input bit src, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < budget) begin
      @(negedge clk);
      if (src ? tx_b_tready : tx_a_tready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    if (!ok) fail_msg(src ? "b_accept" : "a_accept", "timeout waiting for tready");
    else begin
      @(posedge clk); #1;
      if (src) b_acc++;
      else a_acc++;
    end
  endtask

  task automatic send_pkt(input bit src, input int n, input bit [7:0] fmt, input bit [7:0] tag);
    bit ok;
    for (int i = 0; i < n; i++) begin
      drive(src, mk_beat(src, i, n, fmt, tag), 1'b1);
      wait_accept(src, ok);
      if (!ok) break;
    end
    drive(src, '0, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size() + ord_q.size()) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if ((exp_a.size() + exp_b.size() + exp_c.size() + ord_q.size()) != 0) begin
      fail_msg("drain", "expected beats never appeared");
      exp_a.delete(); exp_b.delete(); exp_c.delete(); ord_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Output monitors: compare on every handshake, and check payload holds while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      mon_got = {out_tdata, out_tkeep, out_tlast, out_tuser};
      if (stall_prev) begin
        stall_cnt++;
        check("stall_hold", 640'(mon_got), 640'(mon_held));
      end
      stall_prev = out_tvalid && !out_tready;
      mon_held   = mon_got;
      if (out_tvalid && out_tready) begin
        out_seen++;
        mon_src = out_tdata[264];
        if (mon_src ? (exp_b.size() == 0) : (exp_a.size() == 0)) begin
          fail_msg("out_beat", "unexpected beat on merged stream");
        end else begin
          mon_exp = mon_src ? exp_b.pop_front() : exp_a.pop_front();
          check(mon_src ? "out_b" : "out_a", 640'(mon_got), 640'(mon_exp));
        end
        if (ord_q.size() > 0) begin
          mon_ord = ord_q.pop_front();
          check("out_order", 640'(mon_src), 640'(mon_ord));
        end
      end
      if (rx_b_tvalid && rx_b_tready) begin
        rx_seen++;
        if (exp_c.size() == 0) fail_msg("rx_b_beat", "unexpected commit beat");
        else begin
          mon_exp = exp_c.pop_front();
          check("rx_b_commit", 640'({rx_b_tdata, rx_b_tkeep, rx_b_tlast, rx_b_tuser}),
                640'(mon_exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[8];
    bit    pat[12];
    int    o0, r0, a0, b0, s0;
    beat_t pb;

    vecs[0] = '{src: 1'b0, n: 2, fmt: 8'h60, tag: 8'h15, exp_beats: 2, exp_commit: 1};
    vecs[1] = '{src: 1'b0, n: 1, fmt: 8'h00, tag: 8'h16, exp_beats: 1, exp_commit: 0};
    vecs[2] = '{src: 1'b0, n: 3, fmt: 8'h40, tag: 8'h17, exp_beats: 3, exp_commit: 1};
    vecs[3] = '{src: 1'b1, n: 2, fmt: 8'h20, tag: 8'h18, exp_beats: 2, exp_commit: 0};
    vecs[4] = '{src: 1'b1, n: 1, fmt: 8'h60, tag: 8'h19, exp_beats: 1, exp_commit: 1};
    vecs[5] = '{src: 1'b0, n: 1, fmt: 8'h4A, tag: 8'h1A, exp_beats: 1, exp_commit: 0};
    vecs[6] = '{src: 1'b0, n: 2, fmt: 8'h41, tag: 8'h1B, exp_beats: 2, exp_commit: 0};
    vecs[7] = '{src: 1'b1, n: 4, fmt: 8'h00, tag: 8'h1C, exp_beats: 4, exp_commit: 0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    out_tready  = 1'b1;
    rx_b_tready = 1'b1;
    #12;
    check("reset_out", 640'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser}), 640'(0));
    check("reset_rx_b", 640'({rx_b_tvalid, rx_b_tdata, rx_b_tkeep, rx_b_tlast, rx_b_tuser}),
          640'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie-break straight out of reset: A first, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(1'b0);
      ord_q.push_back(1'b1);
      push_pkt(1'b0, 1, 8'h00, 8'h10 + 8'(i), 1'b0);
      push_pkt(1'b1, 1, 8'h00, 8'h20 + 8'(i), 1'b0);
    end
    fork
      for (int i = 0; i < 3; i++) send_pkt(1'b0, 1, 8'h00, 8'h10 + 8'(i));
      for (int i = 0; i < 3; i++) send_pkt(1'b1, 1, 8'h00, 8'h20 + 8'(i));
    join
    drain();
    check("tie_no_commit", 640'(rx_seen), 640'(0));

    // Table-driven single-packet vectors.
    for (int v = 0; v < 8; v++) begin
      o0 = out_seen;
      r0 = rx_seen;
      push_pkt(vecs[v].src, vecs[v].n, vecs[v].fmt, vecs[v].tag, vecs[v].exp_commit != 0);
      send_pkt(vecs[v].src, vecs[v].n, vecs[v].fmt, vecs[v].tag);
      drain();
      check($sformatf("vec%0d_beats", v), 640'(out_seen - o0), 640'(vecs[v].exp_beats));
      check($sformatf("vec%0d_commits", v), 640'(rx_seen - r0), 640'(vecs[v].exp_commit));
    end

    // One-cycle input-to-output latency.
    push_pkt(1'b0, 1, 8'h00, 8'h33, 1'b0);
    drive(1'b0, mk_beat(1'b0, 0, 1, 8'h00, 8'h33), 1'b1);
    @(negedge clk);
    check("idle_tready_a", 640'(tx_a_tready), 640'(1));
    check("out_empty_before", 640'(out_tvalid), 640'(0));
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("latency_1", 640'(out_tvalid), 640'(1));
    drain();

    // Commit appears on the cycle after the out tlast handshake.
    rx_b_tready = 1'b0;
    push_pkt(1'b0, 1, 8'h40, 8'h44, 1'b1);
    send_pkt(1'b0, 1, 8'h40, 8'h44);
    @(negedge clk);
    check("commit_not_early", 640'(rx_b_tvalid), 640'(0));
    @(negedge clk);
    check("commit_latency", 640'(rx_b_tvalid), 640'(1));
    @(posedge clk); #1;
    rx_b_tready = 1'b1;
    drain();

    // No interleave: B waits for all four A beats.
    r0 = rx_seen;
    for (int i = 0; i < 4; i++) ord_q.push_back(1'b0);
    ord_q.push_back(1'b1);
    push_pkt(1'b0, 4, 8'h60, 8'h50, 1'b1);
    push_pkt(1'b1, 1, 8'h00, 8'h51, 1'b0);
    fork
      send_pkt(1'b0, 4, 8'h60, 8'h50);
      begin
        @(posedge clk); #1;
        send_pkt(1'b1, 1, 8'h00, 8'h51);
      end
    join
    drain();
    check("interleave_commits", 640'(rx_seen - r0), 640'(1));

    // Out back-pressure during a three-beat packet.
    s0 = stall_cnt;
    push_pkt(1'b0, 3, 8'h00, 8'h60, 1'b0);
    fork
      send_pkt(1'b0, 3, 8'h00, 8'h60);
      begin
        for (int k = 0; k < 12; k++) begin
          out_tready = pat[k];
          @(posedge clk); #1;
        end
        out_tready = 1'b1;
      end
    join
    drain();
    check("stalls_seen", 640'(stall_cnt > s0), 640'(1));

    // Credit exhaustion: eight writes pass, the ninth waits for a returned commit.
    rx_b_tready = 1'b0;
    a0 = a_acc;
    b0 = b_acc;
    r0 = rx_seen;
    for (int i = 0; i < 9; i++) push_pkt(1'b0, 1, 8'h60, 8'h70 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) push_pkt(1'b1, 1, 8'h00, 8'h80 + 8'(i), 1'b0);
    fork
      for (int i = 0; i < 9; i++) send_pkt(1'b0, 1, 8'h60, 8'h70 + 8'(i));
      for (int i = 0; i < 6; i++) send_pkt(1'b1, 1, 8'h00, 8'h80 + 8'(i));
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("credit_a_passed", 640'(a_acc - a0), 640'(8));
        check("credit_a_held", 640'(tx_a_tready), 640'(0));
        check("credit_b_flow", 640'(b_acc - b0), 640'(6));
        check("credit_rx_valid", 640'(rx_b_tvalid), 640'(1));
        @(posedge clk); #1;
        rx_b_tready = 1'b1;
      end
    join
    drain();
    check("credit_commits", 640'(rx_seen - r0), 640'(9));

    // Reset mid-packet with two commits queued.
    @(posedge clk); #1;
    rx_b_tready = 1'b0;
    push_pkt(1'b0, 1, 8'h40, 8'h90, 1'b0);
    push_pkt(1'b0, 1, 8'h40, 8'h91, 1'b0);
    send_pkt(1'b0, 1, 8'h40, 8'h90);
    send_pkt(1'b0, 1, 8'h40, 8'h91);
    drain();
    @(negedge clk);
    check("two_commits_queued", 640'(rx_b_tvalid), 640'(1));
    @(posedge clk); #1;
    pb = mk_beat(1'b0, 0, 3, 8'h00, 8'h92);
    exp_a.push_back(pb);
    drive(1'b0, pb, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, mk_beat(1'b0, 1, 3, 8'h00, 8'h92), 1'b1);
    @(posedge clk); #1;
    drive(1'b0, mk_beat(1'b0, 2, 3, 8'h00, 8'h92), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_out", 640'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser}),
          640'(0));
    check("rst_async_rx_b", 640'({rx_b_tvalid, rx_b_tdata, rx_b_tkeep, rx_b_tlast, rx_b_tuser}),
          640'(0));
    check("rst_partial_out", 640'(exp_a.size()), 640'(0));
    drive(1'b0, '0, 1'b0);
    exp_a.delete(); exp_b.delete(); exp_c.delete(); ord_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("commits_discarded", 640'(rx_b_tvalid), 640'(0));

    // A full set of credits is back: eight writes pass with commits held back.
    @(posedge clk); #1;
    budget = 20;
    a0 = a_acc;
    r0 = rx_seen;
    for (int i = 0; i < 8; i++) begin
      push_pkt(1'b0, 1, 8'h60, 8'hA0 + 8'(i), 1'b1);
      send_pkt(1'b0, 1, 8'h60, 8'hA0 + 8'(i));
    end
    check("rst_credits_full", 640'(a_acc - a0), 640'(8));
    @(posedge clk); #1;
    rx_b_tready = 1'b1;
    drain();
    check("rst_fresh_commits", 640'(rx_seen - r0), 640'(8));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
